div_tick_counter: RTL and testbench
===================================

DIV_TICK_COUNTER -- requirements
Module: div_tick_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 10: count modulus; legal range 2..2^WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port init, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port div_in, input, 1 bit: slow square wave from the upstream divide-by-4 stage.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up, input, 1 bit: direction; 1 = up, 0 = down.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH bits: load value.
REQ-010 SHALL have port q, output, WIDTH bits: count value.
REQ-011 SHALL have port tick, output, 1 bit: one-cycle pulse per detected div_in rising edge.
REQ-012 SHALL have port tc, output, 1 bit: one-cycle terminal-count pulse on wrap.
REQ-013 SHALL have port err, output, 1 bit: sticky illegal-load flag.

Function
REQ-014 SHALL implement edge-detect FSM states WAIT_LOW and RUN; reset enters WAIT_LOW.
REQ-015 WAIT_LOW SHALL suppress tick and move to RUN on the first sampled div_in = 0, so div_in high at reset gives no spurious tick.
REQ-016 In RUN, tick SHALL be registered and high for exactly one cycle per 0->1 transition of the sampled div_in; a constant level SHALL give no tick.
REQ-017 Without DIV_TICK_SYNC_EN, tick SHALL rise 2 clk edges after the first edge that samples div_in = 1.
REQ-018 Count update SHALL use the registered tick; q SHALL change on the edge after tick is high, i.e. 1 cycle after tick.
REQ-019 Counting up, on tick & en: q = MODULUS-1 wraps to 0, otherwise q+1.
REQ-020 Counting down, on tick & en: q = 0 wraps to MODULUS-1, otherwise q-1.
REQ-021 tc SHALL be high for exactly the one cycle in which q holds the wrapped value; no tc without a wrap.
REQ-022 With en = 0, q SHALL hold; tick SHALL still pulse.
REQ-023 Priority SHALL be init > load > count; load with a simultaneous count event loads only, with no tc.
REQ-024 load_val < MODULUS SHALL be loaded as given.
REQ-025 load_val >= MODULUS SHALL load MODULUS-1 and set err; err clears only on init.
REQ-026 Arithmetic SHALL be WIDTH-bit unsigned with no out-of-range q ever visible.

Reset
REQ-027 init SHALL set q = 0, tick = 0, tc = 0, err = 0, FSM = WAIT_LOW, and clear all div_in sample and previous-sample registers to 0.
REQ-028 init asserted mid-count SHALL take effect on the next edge and discard any in-flight edge.

Configuration
REQ-029 With macro DIV_TICK_SYNC_EN defined, div_in SHALL pass through a two-flop synchronizer before edge detection.
REQ-030 With DIV_TICK_SYNC_EN defined, tick latency SHALL be 3 edges, 1 more than REQ-017.
REQ-031 Without DIV_TICK_SYNC_EN, a single sampling flop SHALL be used; all other behaviour SHALL be identical.

Structure
REQ-032 Shared package div_tick_pkg SHALL hold the FSM state typedef (WAIT_LOW, RUN) and the default WIDTH/MODULUS constants.
REQ-033 Edge detection (sampling, FSM, tick) SHALL be sub-module div_edge_det; counter, tc and err logic SHALL sit in div_tick_counter.

Verification
REQ-034 Scenario: init 2 cycles, div_in = 1 held, en = 1, up = 1 -> no tick, q = 0; then div_in 0 then 1 -> exactly one tick, 2 edges later (3 with macro); q = 1 one cycle after.
REQ-035 Scenario: div_in = freqDiv4 pattern (2 high / 2 low), en = 1, up = 1 -> ticks every 4 cycles; q 0..9, tc pulses as q reaches 0 after 9.
REQ-036 Scenario: up = 0 from q = 0, one tick -> q = 9, tc = 1 for one cycle.
REQ-037 Scenario: load = 1, load_val = 12 (MODULUS 10) -> q = 9, err = 1; err stays 1 through later loads; init -> err = 0.
REQ-038 Scenario: load = 1, load_val = 5 in the same cycle a tick would count -> q = 5, tc = 0.
REQ-039 Scenario: en = 0 for 3 ticks -> q unchanged, 3 tick pulses; init mid-run -> q = 0, FSM back in WAIT_LOW.

Source files
------------

// File: rtl/div_tick_pkg.sv
// Shared types and defaults for the div_in tick counter.
package div_tick_pkg;

    // Edge-detect FSM: hold off ticks until a genuine low level has been seen
    typedef enum logic {
        WAIT_LOW = 1'b0,
        RUN      = 1'b1
    } edge_state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 10;

endpackage

// File: rtl/div_edge_det.sv
// Rising-edge detector for the slow div_in square wave.
// Optional macro DIV_TICK_SYNC_EN adds a two-flop synchronizer in front of
// the detector, costing one extra edge of tick latency.
module div_edge_det
    import div_tick_pkg::*;
(
    input  logic clk,
    input  logic init,
    input  logic div_in,
    output logic tick
);

`ifdef DIV_TICK_SYNC_EN
    // samp[0..1] synchronizer, samp[2] current, samp[3] previous
    localparam int DEPTH = 4;
`else
    // samp[0] sampling flop, samp[1] current, samp[2] previous
    localparam int DEPTH = 3;
`endif

    logic [DEPTH-1:0] samp;
    // vld[i] marks that samp[i] holds a real sample rather than a reset zero,
    // so a reset-cleared register is never mistaken for a low level
    logic [DEPTH-2:0] vld;
    logic             cur;
    logic             prv;
    edge_state_t      state;

    assign cur = samp[DEPTH-2];
    assign prv = samp[DEPTH-1];

    // Shift div_in down the sample chain together with its valid marker
    always_ff @(posedge clk) begin
        if (init) begin
            samp <= '0;
            vld  <= '0;
        end else begin
            samp <= {samp[DEPTH-2:0], div_in};
            vld  <= {vld[DEPTH-3:0], 1'b1};
        end
    end

    // Arm on the first real low sample, then emit one tick per 0->1 step
    always_ff @(posedge clk) begin
        if (init) begin
            state <= WAIT_LOW;
            tick  <= 1'b0;
        end else begin
            case (state)
                WAIT_LOW: begin
                    tick <= 1'b0;
                    if (vld[DEPTH-2] && !cur)
                        state <= RUN;
                end
                RUN: begin
                    tick <= cur & ~prv;
                end
                default: begin
                    state <= WAIT_LOW;
                    tick  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/div_tick_counter.sv
// Modulo up/down counter advanced by rising edges of div_in.
// Optional macro DIV_TICK_SYNC_EN (handled in div_edge_det) synchronizes
// div_in before edge detection.
module div_tick_counter
    import div_tick_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             init,
    input  logic             div_in,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH compares correctly
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    div_edge_det u_edge (
        .clk    (clk),
        .init   (init),
        .div_in (div_in),
        .tick   (tick)
    );

    // Counter with init > load > count priority; tc marks the wrapped value
    always_ff @(posedge clk) begin
        if (init) begin
            q   <= '0;
            tc  <= 1'b0;
            err <= 1'b0;
        end else if (load) begin
            tc <= 1'b0;
            if ({1'b0, load_val} >= MOD_EXT) begin
                q   <= Q_MAX;
                err <= 1'b1;
            end else begin
                q <= load_val;
            end
        end else if (tick && en) begin
            if (up) begin
                if (q == Q_MAX) begin
                    q  <= '0;
                    tc <= 1'b1;
                end else begin
                    q  <= q + WIDTH'(1);
                    tc <= 1'b0;
                end
            end else begin
                if (q == '0) begin
                    q  <= Q_MAX;
                    tc <= 1'b1;
                end else begin
                    q  <= q - WIDTH'(1);
                    tc <= 1'b0;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_tick_counter.sv
// Directed bench for div_tick_counter (WIDTH 4, MODULUS 10).
module tb_div_tick_counter;

    localparam int W = 4;
    localparam int M = 10;
`ifdef DIV_TICK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         init, div_in, en, up, load;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         tick, tc, err;

    int checks   = 0;
    int failures = 0;
    int n_tick, n_tc, tc_q, last_t, bad_gap, cyc_no, ph;

    div_tick_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk      (clk),
        .init     (init),
        .div_in   (div_in),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tick     (tick),
        .tc       (tc),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        n_tick  = 0;
        n_tc    = 0;
        tc_q    = -1;
        last_t  = -1;
        bad_gap = 0;
    endtask

    // Advance n cycles; optionally drive the 2-high/2-low div4 pattern.
    // Outputs are sampled on the falling edge.
    task automatic run(input int n, input bit pat);
        for (int i = 0; i < n; i++) begin
            if (pat) begin
                div_in = ((ph % 4) < 2);
                ph++;
            end
            @(negedge clk);
            cyc_no++;
            if (tick) begin
                if (last_t >= 0 && (cyc_no - last_t) != 4) bad_gap++;
                last_t = cyc_no;
                n_tick++;
            end
            if (tc) begin
                n_tc++;
                tc_q = 32'(q);
            end
        end
    endtask

    initial begin
        cyc_no = 0; ph = 0;
        clr_stats();
        init = 1'b1; div_in = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;

        // Reset with div_in high, then hold high: no spurious tick
        run(2, 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_tc", 32'(tc), 0);
        chk("rst_err", 32'(err), 0);
        init = 1'b0;
        clr_stats();
        run(8, 0);
        chk("hi_hold_ticks", n_tick, 0);
        chk("hi_hold_q", 32'(q), 0);

        // Single 0->1 step: tick after LAT edges, q one cycle later
        div_in = 1'b0; run(1, 0);
        div_in = 1'b1; run(LAT, 0);
        chk("pre_tick", n_tick, 0);
        run(1, 0);
        chk("tick_lat", 32'(tick), 1);
        chk("q_before_cnt", 32'(q), 0);
        run(1, 0);
        chk("q_after_tick", 32'(q), 1);
        chk("tick_one_cycle", 32'(tick), 0);

        // div4 pattern: 10 ticks 4 cycles apart, one wrap 9->0
        div_in = 1'b0; run(LAT + 3, 0);
        clr_stats(); ph = 0;
        run(40, 1);
        div_in = 1'b0; run(LAT + 3, 0);
        chk("div4_ticks", n_tick, 10);
        chk("div4_gap", bad_gap, 0);
        chk("div4_q", 32'(q), 1);
        chk("div4_tc_cnt", n_tc, 1);
        chk("div4_tc_q", tc_q, 0);

        // Count down from 0: wraps to 9 with tc
        init = 1'b1; up = 1'b0; run(2, 0);
        init = 1'b0; div_in = 1'b0; run(2, 0);
        clr_stats();
        div_in = 1'b1; run(2, 0);
        div_in = 1'b0; run(LAT + 3, 0);
        chk("dn_ticks", n_tick, 1);
        chk("dn_q", 32'(q), 9);
        chk("dn_tc_cnt", n_tc, 1);
        chk("dn_tc_q", tc_q, 9);

        // Illegal load clamps and sets sticky err
        up = 1'b1;
        load = 1'b1; load_val = 4'd12; run(1, 0);
        chk("ld12_q", 32'(q), 9);
        chk("ld12_err", 32'(err), 1);
        load_val = 4'd3; run(1, 0);
        chk("ld3_q", 32'(q), 3);
        chk("ld3_err_sticky", 32'(err), 1);
        load_val = 4'd10; run(1, 0);
        chk("ld10_q", 32'(q), 9);
        load = 1'b0; init = 1'b1; run(1, 0);
        init = 1'b0;
        chk("init_err", 32'(err), 0);
        chk("init_q", 32'(q), 0);

        // Load at the same edge a tick would wrap 9->0: load wins, no tc
        load = 1'b1; load_val = 4'd9; run(1, 0);
        load = 1'b0;
        chk("ld9_q", 32'(q), 9);
        chk("ld9_err", 32'(err), 0);
        div_in = 1'b0; run(2, 0);
        clr_stats();
        div_in = 1'b1; run(LAT, 0);
        run(1, 0);
        chk("ldtick_tick", 32'(tick), 1);
        load = 1'b1; load_val = 4'd5; run(1, 0);
        load = 1'b0;
        chk("ldtick_q", 32'(q), 5);
        chk("ldtick_tc", 32'(tc), 0);
        run(3, 0);
        chk("ldtick_tc_cnt", n_tc, 0);
        chk("ldtick_q_hold", 32'(q), 5);

        // en = 0: three ticks, q holds
        en = 1'b0;
        div_in = 1'b0; run(2, 0);
        clr_stats(); ph = 0;
        run(12, 1);
        div_in = 1'b0; run(LAT + 3, 0);
        chk("en0_ticks", n_tick, 3);
        chk("en0_q", 32'(q), 5);
        chk("en0_tc_cnt", n_tc, 0);

        // init mid-run drops the in-flight edge and re-arms WAIT_LOW
        en = 1'b1;
        clr_stats();
        div_in = 1'b0; run(1, 0);
        div_in = 1'b1; run(1, 0);
        init = 1'b1; run(1, 0);
        init = 1'b0;
        chk("mid_init_q", 32'(q), 0);
        run(LAT + 4, 0);
        chk("mid_init_ticks", n_tick, 0);
        chk("mid_init_q_hold", 32'(q), 0);
        div_in = 1'b0; run(1, 0);
        div_in = 1'b1; run(LAT + 3, 0);
        chk("rearm_ticks", n_tick, 1);
        chk("rearm_q", 32'(q), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
